match_controller: RTL and testbench

Parametrised match sequencer for the Pong design. It generalises the two-player scoring and game-state logic to N players and configurable win and serve timing, and adds pause and serve-delay behaviour. It sits between the ball/collision logic, which reports points, and the render, ball and seven-segment blocks, which consume state, scores and enables. All timing is paced by the shared 1 ms strobe.

---
 rtl/match_controller.sv | 175 +++++++++++++++++
 tb/tb_match_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match sequencer for Pong: N-player scoring, serve delay paced by the 1 ms strobe,
// pause toggling and win detection. Every output is driven straight from a register.
module match_controller #(
   parameter int NUM_PLAYERS    = 2,
   parameter int SCORE_W        = 4,
   parameter int WIN_SCORE      = 9,
   parameter int SERVE_DELAY_MS = 1000,
   localparam int PW            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clk_1ms,
   input  logic                         start,
   input  logic                         pause,
   input  logic                         point_valid,
   input  logic [PW-1:0]                point_player,
   output logic [1:0]                   game_state,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [PW-1:0]                serve_player,
   output logic [PW-1:0]                winner,
   output logic                         ball_enable,
   output logic                         paused,
   output logic                         point_accepted
);
   localparam int CW = (SERVE_DELAY_MS > 0) ? $clog2(SERVE_DELAY_MS + 1) : 1;
   localparam logic [CW-1:0]      DELAY_LOAD = CW'(SERVE_DELAY_MS);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [PW:0]        NP_LIMIT   = (PW + 1)'(NUM_PLAYERS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic                start_prev_r, pause_prev_r;
   logic                start_edge_s, pause_edge_s;
   logic [CW-1:0]       cnt_r, cnt_nxt_s;
   logic [SCORE_W-1:0]  score_r     [NUM_PLAYERS];
   logic [SCORE_W-1:0]  score_nxt_s [NUM_PLAYERS];
   logic [SCORE_W-1:0]  sel_score_s;
   logic [PW-1:0]       serve_player_r, serve_nxt_s;
   logic [PW-1:0]       winner_r, winner_nxt_s;
   logic                paused_r, paused_nxt_s;
   logic                ball_enable_r, point_accepted_r;
   logic                accept_s, win_s;

   assign start_edge_s = start & ~start_prev_r;
   assign pause_edge_s = pause & ~pause_prev_r;

   // A point counts on the old paused value and only for an existing player.
   assign accept_s = (state_r == S_PLAY) && point_valid && !paused_r &&
                     ({1'b0, point_player} < NP_LIMIT);
   assign win_s    = ((sel_score_s + SCORE_W'(1)) == WIN_VAL);

   // Current score of the player named by point_player
   always_comb begin
      sel_score_s = {SCORE_W{1'b0}};
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         sel_score_s = (point_player == PW'(i)) ? score_r[i] : sel_score_s;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= S_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_OVER: begin
            if (start_edge_s) state_nxt_s = S_SERVE;
            else              state_nxt_s = state_r;
         end
         S_SERVE: begin
            if ((cnt_r == {CW{1'b0}}) && !paused_r) state_nxt_s = S_PLAY;
            else                                    state_nxt_s = S_SERVE;
         end
         S_PLAY: begin
            if (accept_s) state_nxt_s = win_s ? S_OVER : S_SERVE;
            else          state_nxt_s = S_PLAY;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Output and datapath next values
   always_comb begin
      cnt_nxt_s    = cnt_r;
      serve_nxt_s  = serve_player_r;
      winner_nxt_s = winner_r;
      for (int i = 0; i < NUM_PLAYERS; i++) score_nxt_s[i] = score_r[i];
      case (state_r)
         S_IDLE, S_OVER: begin
            if (start_edge_s) begin
               for (int i = 0; i < NUM_PLAYERS; i++) score_nxt_s[i] = {SCORE_W{1'b0}};
               serve_nxt_s  = {PW{1'b0}};
               winner_nxt_s = {PW{1'b0}};
               cnt_nxt_s    = DELAY_LOAD;
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         S_SERVE: begin
            if (clk_1ms && !paused_r && (cnt_r != {CW{1'b0}})) cnt_nxt_s = cnt_r - CW'(1);
            else                                                cnt_nxt_s = cnt_r;
         end
         S_PLAY: begin
            if (accept_s) begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  score_nxt_s[i] = (point_player == PW'(i)) ? sel_score_s + SCORE_W'(1)
                                                            : score_r[i];
               end
               if (win_s) begin
                  winner_nxt_s = point_player;
               end else begin
                  serve_nxt_s = point_player;
                  cnt_nxt_s   = DELAY_LOAD;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: cnt_nxt_s = cnt_r;
      endcase

      if ((state_nxt_s == S_IDLE) || (state_nxt_s == S_OVER))
         paused_nxt_s = 1'b0;
      else if (((state_r == S_SERVE) || (state_r == S_PLAY)) && pause_edge_s)
         paused_nxt_s = ~paused_r;
      else
         paused_nxt_s = paused_r;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= {SCORE_W{1'b0}};
         cnt_r            <= {CW{1'b0}};
         serve_player_r   <= {PW{1'b0}};
         winner_r         <= {PW{1'b0}};
         paused_r         <= 1'b0;
         ball_enable_r    <= 1'b0;
         point_accepted_r <= 1'b0;
         start_prev_r     <= 1'b0;
         pause_prev_r     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= score_nxt_s[i];
         cnt_r            <= cnt_nxt_s;
         serve_player_r   <= serve_nxt_s;
         winner_r         <= winner_nxt_s;
         paused_r         <= paused_nxt_s;
         ball_enable_r    <= (state_nxt_s == S_PLAY) && !paused_nxt_s;
         point_accepted_r <= accept_s;
         start_prev_r     <= start;
         pause_prev_r     <= pause;
      end
   end

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
      assign scores[g*SCORE_W +: SCORE_W] = score_r[g];
   end

   assign game_state     = state_r;
   assign serve_player   = serve_player_r;
   assign winner         = winner_r;
   assign ball_enable    = ball_enable_r;
   assign paused         = paused_r;
   assign point_accepted = point_accepted_r;
endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: three players, 3 ms serve delay, win at 9.
// Accepted points are checked by a scoreboard monitor; levels are checked inline.
module tb_match_controller;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clk_1ms = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        point_valid = 1'b0;
   logic [1:0]  point_player = 2'd0;
   logic [1:0]  game_state;
   logic [11:0] scores;
   logic [1:0]  serve_player;
   logic [1:0]  winner;
   logic        ball_enable;
   logic        paused;
   logic        point_accepted;

   int checks = 0;
   int failures = 0;
   logic [19:0] exp_q[$];
   logic [19:0] snap;
   logic [19:0] exp_snap;

   match_controller #(
      .NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(9), .SERVE_DELAY_MS(3)
   ) dut (
      .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .start(start), .pause(pause),
      .point_valid(point_valid), .point_player(point_player),
      .game_state(game_state), .scores(scores), .serve_player(serve_player),
      .winner(winner), .ball_enable(ball_enable), .paused(paused),
      .point_accepted(point_accepted)
   );

   always #5 clk = ~clk;

   assign snap = {game_state, scores, serve_player, winner, ball_enable, paused};

   // Scoreboard monitor: every point_accepted cycle must match the next queued snapshot
   always @(negedge clk) begin
      if (reset && point_accepted) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL point_accepted: unexpected pulse, got %h required no pulse", snap);
         end else begin
            exp_snap = exp_q.pop_front();
            if (snap !== exp_snap) begin
               failures++;
               $display("FAIL point_snapshot: got %h required %h", snap, exp_snap);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] st, input logic [11:0] sc, input logic [1:0] sp,
                           input logic [1:0] w, input logic be, input logic pz);
      exp_q.push_back({st, sc, sp, w, be, pz});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_ms();
      clk_1ms = 1'b1; step(); clk_1ms = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b1; step(); start = 1'b0; step();
   endtask

   task automatic press_pause();
      pause = 1'b1; step(); pause = 1'b0; step();
   endtask

   task automatic point(input logic [1:0] p);
      point_valid = 1'b1; point_player = p; step(); point_valid = 1'b0;
   endtask

   task automatic serve_to_play();
      repeat (3) tick_ms();
      step();
   endtask

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();
      check("rst_state", game_state, 2'd0);
      check("rst_scores", scores, 12'h000);
      check("rst_serve", serve_player, 2'd0);
      check("rst_winner", winner, 2'd0);
      check("rst_ball", ball_enable, 1'b0);
      check("rst_paused", paused, 1'b0);
      check("rst_accept", point_accepted, 1'b0);

      point(2'd1);
      step();
      check("idle_point_ignored", scores, 12'h000);
      press_pause();
      check("idle_pause_ignored", paused, 1'b0);

      press_start();
      check("start_serve", game_state, 2'd1);
      check("serve_ball_off", ball_enable, 1'b0);
      repeat (4) step();
      check("serve_holds_no_tick", game_state, 2'd1);
      repeat (3) tick_ms();
      check("serve_cnt_zero", game_state, 2'd1);
      step();
      check("play_reached", game_state, 2'd2);
      check("play_ball_on", ball_enable, 1'b1);

      push_exp(2'd1, 12'h010, 2'd1, 2'd0, 1'b0, 1'b0);
      point(2'd1);
      check("point_to_serve", game_state, 2'd1);

      tick_ms();
      press_pause();
      check("serve_paused", paused, 1'b1);
      repeat (5) tick_ms();
      step();
      check("serve_frozen", game_state, 2'd1);
      press_pause();
      check("serve_unpaused", paused, 1'b0);
      step();
      check("serve_resume_cnt", game_state, 2'd1);
      tick_ms();
      check("serve_resume_t1", game_state, 2'd1);
      tick_ms();
      check("serve_resume_t2", game_state, 2'd1);
      step();
      check("serve_resume_play", game_state, 2'd2);

      press_pause();
      check("play_paused", paused, 1'b1);
      check("play_paused_ball", ball_enable, 1'b0);
      point(2'd0);
      step();
      check("paused_point_ignored", scores, 12'h010);
      check("paused_point_state", game_state, 2'd2);
      press_pause();
      check("play_resumed_ball", ball_enable, 1'b1);

      push_exp(2'd1, 12'h011, 2'd0, 2'd0, 1'b0, 1'b1);
      pause = 1'b1;
      point(2'd0);
      pause = 1'b0;
      step();
      check("simul_paused", paused, 1'b1);
      check("simul_state", game_state, 2'd1);
      press_pause();
      serve_to_play();
      check("simul_back_play", game_state, 2'd2);

      point(2'd3);
      step();
      check("bad_player_scores", scores, 12'h011);
      check("bad_player_state", game_state, 2'd2);

      push_exp(2'd1, 12'h111, 2'd2, 2'd0, 1'b0, 1'b0);
      point(2'd2);
      serve_to_play();
      for (int k = 2; k <= 9; k++) begin
         if (k < 9) push_exp(2'd1, 12'h110 | 12'(k), 2'd0, 2'd0, 1'b0, 1'b0);
         else       push_exp(2'd3, 12'h119, 2'd0, 2'd0, 1'b0, 1'b0);
         point(2'd0);
         if (k < 9) serve_to_play();
      end
      check("win_state", game_state, 2'd3);
      check("win_winner", winner, 2'd0);
      point(2'd0);
      step();
      check("over_point_ignored", scores, 12'h119);
      press_pause();
      check("over_pause_ignored", paused, 1'b0);

      start = 1'b1;
      step();
      check("restart_state", game_state, 2'd1);
      check("restart_scores", scores, 12'h000);
      serve_to_play();
      check("start_held_play", game_state, 2'd2);
      check("start_held_scores", scores, 12'h000);
      start = 1'b0;
      step();

      push_exp(2'd1, 12'h010, 2'd1, 2'd0, 1'b0, 1'b0);
      point(2'd1);
      serve_to_play();
      press_pause();
      check("pre_reset_paused", paused, 1'b1);
      reset = 1'b0;
      #1;
      check("midrst_state", game_state, 2'd0);
      check("midrst_scores", scores, 12'h000);
      check("midrst_serve", serve_player, 2'd0);
      check("midrst_paused", paused, 1'b0);
      check("midrst_ball", ball_enable, 1'b0);
      step();
      reset = 1'b1;
      step();
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
